s2mm_fb_scheduler: RTL

//  Frame-buffer scheduler for the S2MM FIFO-to-memory writer: owns C_BUF_NUM frame buffers in DDR,

---
 rtl/s2mm_fb_scheduler_pkg.sv | 25 ++
 rtl/s2mm_fb_scheduler_buf_pick.sv | 35 +++
 rtl/s2mm_fb_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/s2mm_fb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s2mm_fb_scheduler_pkg
// Description : Shared FSM encodings and constants for the S2MM frame-buffer
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package s2mm_fb_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } sched_state_t;

    // Cycles spent in STOP before honouring resetting; the writer edge-detects
    // soft_resetn one cycle late, so resetting is not trustworthy before then.
    localparam logic [1:0] C_STOP_HOLD = 2'd2;

    // Buffer indices carry a separate valid flag rather than a reserved code.
    localparam logic C_IDX_VALID   = 1'b1;
    localparam logic C_IDX_INVALID = 1'b0;

endpackage : s2mm_fb_scheduler_pkg
`default_nettype wire

// File: rtl/s2mm_fb_scheduler_buf_pick.sv
`default_nettype none
// ============================================================================
// Module      : s2mm_buf_pick
// Description : Combinational selector returning the lowest buffer index not
//               claimed by either of two (optionally valid) exclusions.
// Revision    : 1.0 - initial release
// ============================================================================
module s2mm_buf_pick #(
    parameter int C_BUF_NUM  = 3,
    parameter int C_IDX_BITS = 2
) (
    input  logic [C_IDX_BITS-1:0] excl_a,
    input  logic                  excl_a_vld,
    input  logic [C_IDX_BITS-1:0] excl_b,
    input  logic                  excl_b_vld,
    output logic [C_IDX_BITS-1:0] idx
);

    logic w_found;

    always_comb begin
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < C_BUF_NUM; i++) begin
            if (!w_found
                && !(excl_a_vld && (excl_a == C_IDX_BITS'(i)))
                && !(excl_b_vld && (excl_b == C_IDX_BITS'(i)))) begin
                idx     = C_IDX_BITS'(i);
                w_found = 1'b1;
            end
        end
    end

endmodule : s2mm_buf_pick
`default_nettype wire

// File: rtl/s2mm_fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : s2mm_fb_scheduler
// Description : Triple-buffer frame scheduler between the register block, the
//               S2MM writer and a downstream frame reader.
// Revision    : 1.0 - initial release
// ============================================================================
module s2mm_fb_scheduler
    import s2mm_fb_scheduler_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_BUF_NUM    = 3,
    parameter int C_IDX_BITS   = 2,
    parameter int C_CNT_BITS   = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              enable,
    input  logic [C_BUF_NUM*C_ADDR_WIDTH-1:0] buf_addrs,
    output logic                              soft_resetn,
    input  logic                              resetting,
    input  logic                              frame_pulse,
    output logic [C_ADDR_WIDTH-1:0]           wr_base_addr,
    output logic [C_IDX_BITS-1:0]             wr_idx,
    input  logic                              rd_req,
    output logic                              rd_ack,
    output logic                              rd_new,
    output logic [C_IDX_BITS-1:0]             rd_idx,
    output logic [C_ADDR_WIDTH-1:0]           rd_base_addr,
    output logic                              rd_valid,
    output logic                              busy,
    output logic [C_CNT_BITS-1:0]             frame_cnt,
    output logic [C_CNT_BITS-1:0]             drop_cnt
);

    localparam int C_IDX_SPAN = 2 ** C_IDX_BITS;

    sched_state_t r_state, w_state_nxt;
    logic [1:0]   r_hold, w_hold_nxt;

    logic [C_IDX_BITS-1:0] r_wr_idx;
    logic [C_IDX_BITS-1:0] r_l_idx;
    logic                  r_l_vld;
    logic                  r_l_read;
    logic [C_IDX_BITS-1:0] r_rd_idx;
    logic                  r_rd_valid;
    logic                  r_rd_ack;
    logic                  r_rd_new;
    logic                  r_soft_resetn;
    logic                  r_busy;
    logic [C_CNT_BITS-1:0] r_frame_cnt;
    logic [C_CNT_BITS-1:0] r_drop_cnt;

    logic                  w_entering;
    logic                  w_retire;
    logic [C_IDX_BITS-1:0] w_l_idx_new;
    logic                  w_l_vld_new;
    logic                  w_l_read_eff;
    logic                  w_grant;
    logic [C_IDX_BITS-1:0] w_r_idx_new;
    logic                  w_r_vld_new;
    logic                  w_drop;
    logic [C_IDX_BITS-1:0] w_pick;

    logic [C_ADDR_WIDTH-1:0] w_bufs [C_IDX_SPAN];

    generate
        for (genvar gi = 0; gi < C_IDX_SPAN; gi++) begin : g_unpack
            if (gi < C_BUF_NUM) begin : g_real
                assign w_bufs[gi] = buf_addrs[gi*C_ADDR_WIDTH +: C_ADDR_WIDTH];
            end else begin : g_pad
                assign w_bufs[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_STOP;
                    w_hold_nxt  = C_STOP_HOLD;
                end
            end
            ST_STOP: begin
                if (r_hold != 2'd0) begin
                    w_hold_nxt = r_hold - 2'd1;
                end else if (!resetting) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Retire is resolved before grant so a same-cycle rd_req sees the frame
    // that just completed.
    assign w_entering   = (r_state == ST_IDLE) && (w_state_nxt == ST_RUN);
    assign w_retire     = frame_pulse && ((r_state == ST_RUN) || (r_state == ST_STOP));
    assign w_l_idx_new  = w_retire ? r_wr_idx : r_l_idx;
    assign w_l_vld_new  = w_retire | r_l_vld;
    assign w_l_read_eff = w_retire ? 1'b0 : r_l_read;
    assign w_grant      = rd_req && w_l_vld_new && !w_l_read_eff;
    assign w_r_idx_new  = w_grant ? w_l_idx_new : r_rd_idx;
    assign w_r_vld_new  = w_grant | r_rd_valid;
    assign w_drop       = w_retire && r_l_vld && !r_l_read
                          && !(r_rd_valid && (r_l_idx == r_rd_idx));

    // On RUN entry L is discarded but the reader may still hold a buffer from
    // the previous run, so the first target must still avoid it.
    s2mm_buf_pick #(
        .C_BUF_NUM  (C_BUF_NUM),
        .C_IDX_BITS (C_IDX_BITS)
    ) u_buf_pick (
        .excl_a     (w_l_idx_new),
        .excl_a_vld (w_l_vld_new & ~w_entering),
        .excl_b     (w_r_idx_new),
        .excl_b_vld (w_r_vld_new),
        .idx        (w_pick)
    );

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            r_wr_idx      <= '0;
            r_l_idx       <= '0;
            r_l_vld       <= C_IDX_INVALID;
            r_l_read      <= 1'b0;
            r_rd_idx      <= '0;
            r_rd_valid    <= C_IDX_INVALID;
            r_rd_ack      <= 1'b0;
            r_rd_new      <= 1'b0;
            r_soft_resetn <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_soft_resetn <= (w_state_nxt == ST_RUN);
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_rd_ack      <= rd_req;
            r_rd_new      <= w_grant;
            if (w_grant) begin
                r_rd_idx   <= w_l_idx_new;
                r_rd_valid <= C_IDX_VALID;
            end
            if (w_retire) begin
                r_l_idx     <= r_wr_idx;
                r_l_vld     <= C_IDX_VALID;
                r_frame_cnt <= r_frame_cnt + 1'b1;
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
            if (w_retire || w_grant) begin
                r_l_read <= w_grant;
            end
            if (w_retire || w_entering) begin
                r_wr_idx <= w_pick;
            end
            if (w_entering) begin
                r_l_vld  <= C_IDX_INVALID;
                r_l_read <= 1'b0;
            end
        end
    end

    assign soft_resetn  = r_soft_resetn;
    assign busy         = r_busy;
    assign wr_idx       = r_wr_idx;
    assign wr_base_addr = w_bufs[r_wr_idx];
    assign rd_ack       = r_rd_ack;
    assign rd_new       = r_rd_new;
    assign rd_idx       = r_rd_idx;
    assign rd_valid     = r_rd_valid;
    assign rd_base_addr = w_bufs[r_rd_idx];
    assign frame_cnt    = r_frame_cnt;
    assign drop_cnt     = r_drop_cnt;

endmodule : s2mm_fb_scheduler
`default_nettype wire
